// File: rtl/move_player_if.sv
// Command/status bundle between a sequence host and move_player.
// The host side also returns the stepper's move_done completion pulse.
interface move_player_if;
   logic         load;
   logic [199:0] seq;
   logic         reverse;
   logic         pause;
   logic [3:0]   next_move;
   logic         start_move;
   logic         move_done;
   logic         busy;
   logic         done;
   logic [7:0]   num_moves;
   logic [7:0]   curr_step;
   logic         bad_move;

   modport master (
      output load, seq, reverse, pause, move_done,
      input  next_move, start_move, busy, done, num_moves, curr_step, bad_move
   );

   modport slave (
      input  load, seq, reverse, pause, move_done,
      output next_move, start_move, busy, done, num_moves, curr_step, bad_move
   );
endinterface

// File: rtl/move_player.sv
// Plays a packed 50-nibble cube move sequence (forward or inverted) to a stepper,
// one move at a time with a settle gap; all outputs are registered.
module move_player #(
   parameter int unsigned SETTLE_CYCLES = 250000
) (
   input logic         clock,
   input logic         reset,
   move_player_if.slave io
);

   localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE, ST_SCAN, ST_ISSUE, ST_WAIT, ST_SETTLE, ST_DONE
   } state_t;

   state_t         state_q, state_d;
   logic [199:0]   seq_q, seq_d;
   logic           rev_q, rev_d;
   logic [5:0]     idx_q, idx_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [3:0]     next_move_q, next_move_d;
   logic           start_move_q, start_move_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic [7:0]     num_q, num_d;
   logic [7:0]     step_q, step_d;
   logic           bad_q, bad_d;

   logic [3:0]     nib;
   logic           nib_bad;
   logic [5:0]     idx_step;
   logic [7:0]     step_inc;

   // idx_q is the scan index in SCAN and the playback pointer afterwards
   assign nib      = 4'(seq_q >> {idx_q, 2'b00});
   assign nib_bad  = (nib == 4'd1) || (nib >= 4'd14);
   assign idx_step = rev_q ? (idx_q + 6'd1) : (idx_q - 6'd1);
   assign step_inc = step_q + 8'd1;

   always_comb begin
      state_d      = state_q;
      seq_d        = seq_q;
      rev_d        = rev_q;
      idx_d        = idx_q;
      cnt_d        = cnt_q;
      next_move_d  = next_move_q;
      start_move_d = 1'b0;
      busy_d       = busy_q;
      done_d       = done_q;
      num_d        = num_q;
      step_d       = step_q;
      bad_d        = bad_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (io.load) begin
               seq_d   = io.seq;
               rev_d   = io.reverse;
               step_d  = 8'd0;
               num_d   = 8'd0;
               done_d  = 1'b0;
               bad_d   = 1'b0;
               busy_d  = 1'b1;
               idx_d   = 6'd49;
               state_d = ST_SCAN;
            end
         end
         ST_SCAN: begin
            if (nib != 4'd0) begin
               num_d   = {2'b00, idx_q} + 8'd1;
               idx_d   = rev_q ? 6'd0 : idx_q;
               state_d = ST_ISSUE;
            end else if (idx_q == 6'd0) begin
               num_d   = 8'd0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = ST_DONE;
            end else begin
               idx_d = idx_q - 6'd1;
            end
         end
         ST_ISSUE: begin
            if (!io.pause) begin
               if (nib == 4'd0 || nib_bad) begin
                  bad_d  = bad_q | nib_bad;
                  step_d = step_inc;
                  idx_d  = idx_step;
                  if (step_inc >= num_q) begin
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                     state_d = ST_DONE;
                  end
               end else begin
                  // inverse of a move is the paired code differing in the LSB
                  next_move_d  = nib ^ {3'b000, rev_q};
                  start_move_d = 1'b1;
                  state_d      = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (io.move_done) begin
               step_d  = step_inc;
               idx_d   = idx_step;
               cnt_d   = '0;
               state_d = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (step_q < num_q) begin
                  state_d = ST_ISSUE;
               end else begin
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = ST_DONE;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         seq_q        <= '0;
         rev_q        <= 1'b0;
         idx_q        <= '0;
         cnt_q        <= '0;
         next_move_q  <= 4'd0;
         start_move_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         num_q        <= 8'd0;
         step_q       <= 8'd0;
         bad_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         seq_q        <= seq_d;
         rev_q        <= rev_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         next_move_q  <= next_move_d;
         start_move_q <= start_move_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         num_q        <= num_d;
         step_q       <= step_d;
         bad_q        <= bad_d;
      end
   end

   assign io.next_move  = next_move_q;
   assign io.start_move = start_move_q;
   assign io.busy       = busy_q;
   assign io.done       = done_q;
   assign io.num_moves  = num_q;
   assign io.curr_step  = step_q;
   assign io.bad_move   = bad_q;

endmodule
